aes_iter_core: RTL and testbench
================================

# aes_iter_core

Iterative AES-128 engine that terminates the `start`/`done` command protocol driven by the AES host side, such as the encryption benches and the host controller. It accepts one 128-bit block, a key and a direction per command and computes one round per clock. It returns the result with a one-cycle `done` pulse and a cycle count for performance monitoring. It is the non-pipelined responder behind the top-level mode select.

## Interface
- `CNT_W`, 6: width of `cycle_count`; the counter saturates at all-ones.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: command strobe; sampled only when `busy`=0.
- `data_in` input 128: plaintext or ciphertext, byte 0 in bits [127:120] (FIPS-197 order).
- `key` input 128: AES-128 cipher key, same byte order.
- `decrypt` input 1: 0 = encrypt, 1 = decrypt.
- `busy` output 1: high from the cycle after `start` is accepted until `done` is asserted.
- `done` output 1: one-cycle pulse when `data_out` becomes valid.
- `data_out` output 128: result; holds its value until the next `done`.
- `cycle_count` output CNT_W: cycles from the accepting edge to the `done` edge, inclusive of the `done` edge; holds its value until the next accepted `start`.

## Operation
- FSM states: IDLE, KEYX, ROUND, FIN.
- IDLE with `start`=1:
  - Capture `data_in`, `key` and `decrypt`.
  - Clear the cycle counter and set `busy`.
  - Encrypt goes to ROUND with state = `data_in` ^ `key`.
  - Decrypt goes to KEYX.
- KEYX (decrypt only):
  - 10 cycles of forward key expansion: round keys 1..10 written into an 11×128 key store; key 0 is the captured key.
  - Then go to ROUND with state = `data_in` ^ rk10.
- ROUND: 10 cycles with round index r = 1..10.
  - Encrypt applies SubBytes, ShiftRows, MixColumns (skipped at r=10) and AddRoundKey.
  - Encrypt computes round keys on the fly: Rcon 01,02,04,08,10,20,40,80,1B,36.
  - Decrypt applies InvShiftRows, InvSubBytes, AddRoundKey(rk[10-r]) and InvMixColumns (skipped at r=10).
- FIN: register the result into `data_out`, pulse `done`, clear `busy`, return to IDLE.
- S-box and inverse S-box are combinational: GF(2^8) inverse plus affine map. 16 instances serve the state and 4 serve the key path.
- `start` while `busy`=1 is ignored; no queueing.
- Input changes after acceptance have no effect.
- `rst` mid-operation aborts the command: no `done`, state goes to IDLE, and outputs return to reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `data_out`=0, `cycle_count`=0.
- Encrypt latency: `start` is sampled at edge N; `done`=1 after edge N+11; `cycle_count`=11.
- Decrypt latency: `done`=1 after edge N+21; `cycle_count`=21.
- `busy` is high after edge N through the edge that raises `done`. `done` and `busy` are never high together.
- Back-to-back commands: `start` may be asserted in the cycle where `done`=1, and it is accepted. The new command's `cycle_count` clears on acceptance, while `data_out` holds the previous result until its own `done`.
- `cycle_count` saturates at 2^CNT_W−1 and never wraps.

## Configuration
- `AES_DECRYPT_EN` defined:
  - Full behaviour as above.
  - Key store, KEYX state and inverse datapath are present.
- `AES_DECRYPT_EN` undefined:
  - `decrypt` is ignored and every command encrypts with 11-cycle latency.
  - KEYX, the key store and the inverse logic are removed.

## Test plan
- Encrypt, reference vector, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> `data_out`=69c4e0d86a7b0430d8cdb78070b4c55a, `cycle_count`=11.
- Decrypt, reference vector, same key, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> `data_out`=00112233445566778899aabbccddeeff, `cycle_count`=21. Without `AES_DECRYPT_EN` the same stimulus yields the encryption of the ct in 11 cycles.
- Encrypt, all-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Pulse `start` 3 times while `busy` -> exactly one `done`.
- Back-to-back: second `start` in the `done` cycle with a different pt. Require the first result held until the second `done` 11 cycles later and the second result correct.
- Assert `rst` at cycle 5 of an encrypt -> no `done`, all outputs 0 the next cycle. A following command completes correctly.
- Change `data_in`/`key` every cycle after acceptance -> result still matches the captured inputs.

Source files
------------

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 engine, one round per clock, start/done command protocol
// Optional feature macro: AES_DECRYPT_EN adds the decrypt path (KEYX key expansion, key store, inverse rounds).
// Ports: clk, rst (sync, active-high); start, data_in, key, decrypt form a command (sampled when idle);
//        busy while a command runs, done one-cycle result pulse, data_out result (held until next done),
//        cycle_count accept-to-done latency of the last command (saturating, CNT_W bits).
module aes_iter_core #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     data_in,
    input  logic [127:0]     key,
    input  logic             decrypt,
    output logic             busy,
    output logic             done,
    output logic [127:0]     data_out,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, KEYX, ROUND, FIN} st_t;
    st_t st, st_nx;
    logic [127:0] state, kreg, knext, ss, enc_nx, round_nx;
    logic [3:0] rnd;
    logic [7:0] rcon;
    logic last, go_dec;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ t : p;
            t = xt(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = ginv(x);
        return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
    endfunction

    // Byte b sits at bits [127-8b -: 8]; byte b is row b%4, column b/4
    function automatic logic [127:0] sub_shift(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox(x[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign last   = rnd == 4'd10;
    assign knext  = key_exp(kreg, rcon);
    assign ss     = sub_shift(state);
    assign enc_nx = (last ? ss : mix(ss)) ^ knext;

`ifdef AES_DECRYPT_EN
    logic [127:0] ks [0:10];
    logic [127:0] din_q, ark, dec_nx;
    logic [3:0] kidx;
    logic dec_q;

    function automatic logic [7:0] isbox(input logic [7:0] s);
        return ginv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = isbox(x[127-8*(r+4*((c-r+4)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            o[127-32*c -: 32] = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                                 gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                                 gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                                 gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    assign go_dec   = decrypt;
    assign kidx     = 4'd10 - rnd;
    assign ark      = inv_shift_sub(state) ^ ks[kidx];
    assign dec_nx   = last ? ark : inv_mix(ark);
    assign round_nx = dec_q ? dec_nx : enc_nx;

    always_ff @(posedge clk) begin
        if (st == IDLE && start)
            ks[0] <= key;
        else if (st == KEYX)
            ks[rnd] <= knext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= '0;
            dec_q <= 1'b0;
        end else if (st == IDLE && start) begin
            din_q <= data_in;
            dec_q <= decrypt;
        end
    end
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign go_dec         = 1'b0;
    assign round_nx       = enc_nx;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = start ? (go_dec ? KEYX : ROUND) : IDLE;
            KEYX:    st_nx = last ? ROUND : KEYX;
            ROUND:   st_nx = last ? FIN : ROUND;
            FIN:     st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            data_out    <= '0;
            cycle_count <= '0;
            state       <= '0;
            kreg        <= '0;
            rnd         <= '0;
            rcon        <= '0;
        end else begin
            done <= 1'b0;
            if (busy && cycle_count != '1)
                cycle_count <= cycle_count + CNT_W'(1);
            case (st)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    cycle_count <= '0;
                    kreg        <= key;
                    rnd         <= 4'd1;
                    rcon        <= 8'h01;
                    state       <= data_in ^ key;
                end
`ifdef AES_DECRYPT_EN
                // Expansion leaves rk10 on knext in its last cycle, giving the initial decrypt state directly
                KEYX: begin
                    kreg <= knext;
                    rnd  <= last ? 4'd1 : rnd + 4'd1;
                    rcon <= last ? 8'h01 : xt(rcon);
                    if (last)
                        state <= din_q ^ knext;
                end
`endif
                ROUND: begin
                    state <= round_nx;
                    kreg  <= knext;
                    rnd   <= rnd + 4'd1;
                    rcon  <= xt(rcon);
                end
                FIN: begin
                    data_out <= state;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed-vector bench for aes_iter_core
module tb_aes_iter_core;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, decrypt = 1'b0;
    logic [127:0] data_in = '0, key = '0;
    logic busy, done;
    logic [127:0] data_out;
    logic [5:0] cycle_count;

    aes_iter_core #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key(key), .decrypt(decrypt),
        .busy(busy), .done(done), .data_out(data_out), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, done_cnt = 0, overlap = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (done && busy) overlap++;
    end

    typedef struct {
        logic [127:0] k;
        logic [127:0] d;
        logic         dc;
        logic [127:0] e;
        int           n;
    } vec_t;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C3  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P4  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] C4  = 128'h43b1cd7f598ece23881b00e3ed030688;

    vec_t v [8];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Call just after a clock edge with the engine idle (or in its done cycle)
    task automatic run(input logic [127:0] k, input logic [127:0] d, input logic dc,
                       output logic [127:0] o, output int c, output int lat);
        key = k;
        data_in = d;
        decrypt = dc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        o = data_out;
        c = int'(cycle_count);
    endtask

    initial begin
        logic [127:0] o;
        int c, lat, d0, held_bad;
        v[0] = '{K0, P0, 1'b0, C0, 11};
        v[1] = '{128'h0, 128'h0, 1'b0, CZ, 11};
        v[2] = '{K1, P1, 1'b0, C1, 11};
        v[3] = '{K1, P2, 1'b0, C2, 11};
`ifdef AES_DECRYPT_EN
        v[4] = '{K0, C0, 1'b1, P0, 21};
        v[5] = '{K1, C3, 1'b1, P3, 21};
        v[6] = '{128'h0, CZ, 1'b1, 128'h0, 21};
`else
        v[4] = '{K0, P0, 1'b1, C0, 11};
        v[5] = '{K1, P3, 1'b1, C3, 11};
        v[6] = '{128'h0, 128'h0, 1'b1, CZ, 11};
`endif
        v[7] = '{K1, P4, 1'b0, C4, 11};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_data_out", data_out, 128'd0);
        chk("reset_cycle_count", 128'(cycle_count), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run(v[i].k, v[i].d, v[i].dc, o, c, lat);
            chk($sformatf("vec%0d_data_out", i), o, v[i].e);
            chk($sformatf("vec%0d_cycle_count", i), 128'(c), 128'(v[i].n));
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(v[i].n));
        end

`ifndef AES_DECRYPT_EN
        run(K0, C0, 1'b1, o, c, lat);
        chk("nodec_cycle_count", 128'(c), 128'd11);
        chk("nodec_not_plaintext", 128'(o == P0), 128'd0);
`endif

        // start pulses while busy must be ignored
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        key = '0;
        data_in = '0;
        decrypt = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 start = 1'b1;
            data_in = '1;
            key = K1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        repeat (30) @(posedge clk);
        #1;
        chk("busy_ignore_done_count", 128'(done_cnt - d0), 128'd1);
        chk("busy_ignore_data_out", data_out, CZ);
        chk("busy_ignore_cycle_count", 128'(cycle_count), 128'd11);

        // back-to-back: second start in the done cycle
        run(K0, P0, 1'b0, o, c, lat);
        key = K1;
        data_in = P1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_count_cleared", 128'(cycle_count), 128'd0);
        held_bad = 0;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            if (data_out !== C0) held_bad++;
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_first_result_held", 128'(held_bad), 128'd0);
        chk("b2b_latency", 128'(lat), 128'd11);
        chk("b2b_second_result", data_out, C1);
        chk("b2b_cycle_count", 128'(cycle_count), 128'd11);

        // reset in the middle of an encrypt
        repeat (2) @(posedge clk);
        #1;
        key = K1;
        data_in = P2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        d0 = done_cnt;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_done", 128'(done), 128'd0);
        chk("midrst_data_out", data_out, 128'd0);
        chk("midrst_cycle_count", 128'(cycle_count), 128'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        run(K1, P2, 1'b0, o, c, lat);
        chk("post_rst_data_out", o, C2);
        chk("post_rst_latency", 128'(lat), 128'd11);

        // inputs scrambled every cycle after acceptance
        repeat (2) @(posedge clk);
        #1;
        key = K0;
        data_in = P0;
        decrypt = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            decrypt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        decrypt = 1'b0;
        chk("scramble_data_out", data_out, C0);
        chk("scramble_latency", 128'(lat), 128'd11);

        chk("done_busy_overlap", 128'(overlap), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
